// File: rtl/Public_Info.sv
// Shared decode/issue types and machine-wide sizing constants.
package Public_Info;

  localparam int ISSUE_WIDTH = 2;
  localparam int IQ_DEPTH    = 8;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] instr;
    logic        o_valid;
  } PC_set;

endpackage

// File: rtl/inst_queue.sv
// Dual-wide decode-to-issue FIFO: 0-2 pushes and 0-2 pops per cycle, 1-cycle push-to-issue latency.
// Backpressure: o_ready drops below 2 free entries and then pushes are ignored; flush and rst empty the queue.
module inst_queue
  import Public_Info::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  PC_set            i_set1,
  input  PC_set            i_set2,
  input  logic [1:0]       i_push_valid,
  output logic             o_ready,
  output PC_set            o_set1,
  output PC_set            o_set2,
  output logic [1:0]       o_is_valid,
  input  logic [1:0]       i_usingNUM,
  output logic [PTR_W:0]   o_count
);

  localparam int CNT_W = PTR_W + 1;

  PC_set            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [1:0]       push_n;
  logic [1:0]       pop_req;
  logic [1:0]       pop_n;
  PC_set            wr0;

  // DEPTH is a power of two, so natural overflow of the pointer width is the modulo wrap.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] k);
    return p + PTR_W'(k);
  endfunction

  assign o_ready    = (count <= CNT_W'(DEPTH - 2));
  assign o_is_valid = {count >= CNT_W'(1), count >= CNT_W'(2)};
  assign o_count    = count;

  always_comb begin
    o_set1         = mem[head];
    o_set2         = mem[ptr_add(head, 2'd1)];
    o_set1.o_valid = o_is_valid[1];
    o_set2.o_valid = o_is_valid[0];
  end

  always_comb begin
    push_n = 2'd0;
    if (o_ready) begin
      case (i_push_valid)
        2'b11:        push_n = 2'd2;
        2'b10, 2'b01: push_n = 2'd1;
        default:      push_n = 2'd0;
      endcase
    end
    // A lone younger push lands in the first free slot to keep program order compact.
    wr0     = i_push_valid[1] ? i_set1 : i_set2;
    pop_req = (i_usingNUM == 2'd3) ? 2'd2 : i_usingNUM;
    pop_n   = (CNT_W'(pop_req) > count) ? count[1:0] : pop_req;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= ptr_add(head, pop_n);
      tail  <= ptr_add(tail, push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_n != 2'd0) mem[tail] <= wr0;
      if (push_n == 2'd2) mem[ptr_add(tail, 2'd1)] <= i_set2;
    end
  end

endmodule
